// File: rtl/text_mem_arbiter.sv
// Text-memory arbiter: shares a single-port, synchronous-read text memory
// between core instruction fetch, core data port and an external loader.
// Fetch and data are served round-robin; the loader takes exclusive
// ownership through a RUN -> DRAIN -> LOAD sequence.
module text_mem_arbiter #(
  parameter int unsigned TEXT_BITS = 16,
  parameter int unsigned CNT_BITS  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  // core instruction fetch
  input  logic                 f_req,
  input  logic [TEXT_BITS-1:0] f_addr,
  output logic                 f_gnt,
  output logic                 f_rvalid,
  output logic [31:0]          f_rdata,
  // core data port
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [TEXT_BITS-1:0] d_addr,
  input  logic [3:0]           d_be,
  input  logic [31:0]          d_wdata,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [31:0]          d_rdata,
  // boot / debug loader
  input  logic                 ld_en,
  input  logic                 ld_valid,
  input  logic                 ld_we,
  input  logic [TEXT_BITS-3:0] ld_addr,
  input  logic [31:0]          ld_wdata,
  output logic                 ld_ack,
  output logic [31:0]          ld_rdata,
  output logic                 ld_active,
  output logic [CNT_BITS-1:0]  ld_count,
  // text memory
  output logic [TEXT_BITS-3:0] m_addr,
  output logic                 m_we,
  output logic [3:0]           m_be,
  output logic [31:0]          m_wdata,
  input  logic [31:0]          m_rdata
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // Identifies which requester owns the read data returning next cycle.
  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_FETCH = 2'd1,
    TAG_DATA  = 2'd2,
    TAG_LOAD  = 2'd3
  } tag_t;

  state_t               state, state_nxt;
  tag_t                 tag, tag_nxt;
  logic                 last_data, last_data_nxt;
  logic [CNT_BITS-1:0]  count;
  logic                 count_inc, count_clr;

  // Byte-offset bits of the core addresses are intentionally ignored.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{f_addr[1:0], d_addr[1:0]};

  // State, round-robin pointer, response tag and loader write counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      tag       <= TAG_NONE;
      last_data <= 1'b1;
      count     <= '0;
    end else begin
      state     <= state_nxt;
      tag       <= tag_nxt;
      last_data <= last_data_nxt;
      if (count_clr)
        count <= '0;
      else if (count_inc && (count != '1))
        count <= count + CNT_BITS'(1);
    end
  end

  // Next-state, grant and memory-port decode.
  always_comb begin
    state_nxt     = state;
    tag_nxt       = TAG_NONE;
    last_data_nxt = last_data;
    f_gnt         = 1'b0;
    d_gnt         = 1'b0;
    m_addr        = '0;
    m_we          = 1'b0;
    m_be          = '0;
    m_wdata       = '0;
    count_inc     = 1'b0;
    count_clr     = 1'b0;
    case (state)
      ST_RUN: begin
        if (ld_en) begin
          state_nxt = ST_DRAIN;
        end else if (f_req && (!d_req || last_data)) begin
          f_gnt         = 1'b1;
          m_addr        = f_addr[TEXT_BITS-1:2];
          tag_nxt       = TAG_FETCH;
          last_data_nxt = 1'b0;
        end else if (d_req) begin
          d_gnt         = 1'b1;
          m_addr        = d_addr[TEXT_BITS-1:2];
          last_data_nxt = 1'b1;
          if (d_we) begin
            m_we    = 1'b1;
            m_be    = d_be;
            m_wdata = d_wdata;
          end else begin
            tag_nxt = TAG_DATA;
          end
        end
      end
      ST_DRAIN: begin
        if (ld_en) begin
          state_nxt = ST_LOAD;
          count_clr = 1'b1;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_LOAD: begin
        // An access strobed in the same cycle ld_en falls is still issued.
        if (ld_valid) begin
          m_addr  = ld_addr;
          tag_nxt = TAG_LOAD;
          if (ld_we) begin
            m_we      = 1'b1;
            m_be      = '1;
            m_wdata   = ld_wdata;
            count_inc = 1'b1;
          end
        end
        if (!ld_en)
          state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Response routing decoded from the registered tag.
  always_comb begin
    f_rvalid  = (tag == TAG_FETCH);
    d_rvalid  = (tag == TAG_DATA);
    ld_ack    = (tag == TAG_LOAD);
    ld_active = (state == ST_LOAD);
    ld_count  = count;
    f_rdata   = m_rdata;
    d_rdata   = m_rdata;
    ld_rdata  = m_rdata;
  end

endmodule

// File: tb/tb_text_mem_arbiter.sv
// Directed bench for text_mem_arbiter with a behavioural synchronous-read
// text memory attached to the memory port.
module tb_text_mem_arbiter;

  logic        clock, reset;
  logic        f_req, f_gnt, f_rvalid;
  logic [15:0] f_addr;
  logic [31:0] f_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [15:0] d_addr;
  logic [3:0]  d_be;
  logic [31:0] d_wdata, d_rdata;
  logic        ld_en, ld_valid, ld_we, ld_ack, ld_active;
  logic [13:0] ld_addr;
  logic [31:0] ld_wdata, ld_rdata;
  logic [15:0] ld_count;
  logic [13:0] m_addr;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_wdata, m_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:16383];

  text_mem_arbiter #(.TEXT_BITS(16), .CNT_BITS(16)) dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ld_en(ld_en), .ld_valid(ld_valid), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_ack(ld_ack), .ld_rdata(ld_rdata),
    .ld_active(ld_active), .ld_count(ld_count),
    .m_addr(m_addr), .m_we(m_we), .m_be(m_be), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read memory with byte-enabled writes.
  always @(posedge clock) begin
    if (m_we) begin
      for (int b = 0; b < 4; b++)
        if (m_be[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
    end
    m_rdata <= mem[m_addr];
  end

  typedef struct {
    logic        f_req;
    logic [15:0] f_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        e_fgnt;
    logic        e_dgnt;
    logic        e_we;
    logic [3:0]  e_be;
    logic [13:0] e_addr;
    logic        e_frv;
    logic        e_drv;
    logic        e_rdchk;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(
    input logic fr, input logic [15:0] fa, input logic dr, input logic dw,
    input logic [15:0] da, input logic [3:0] be, input logic [31:0] wd,
    input logic gf, input logic gd, input logic we, input logic [3:0] ebe,
    input logic [13:0] ea, input logic frv, input logic drv,
    input logic rc, input logic [31:0] rd);
    vec_t v;
    v.f_req = fr; v.f_addr = fa; v.d_req = dr; v.d_we = dw; v.d_addr = da;
    v.d_be = be; v.d_wdata = wd; v.e_fgnt = gf; v.e_dgnt = gd; v.e_we = we;
    v.e_be = ebe; v.e_addr = ea; v.e_frv = frv; v.e_drv = drv;
    v.e_rdchk = rc; v.e_rdata = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    f_req = 0; f_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_be = '0; d_wdata = '0;
    ld_en = 0; ld_valid = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    mem[4] = 32'h00500093;
    mem[8] = 32'h11111111;
    mem[2] = 32'h01020304;
    m_rdata = '0;

    //        f  faddr     d  we daddr     be    wdata         gf gd we be    addr frv drv chk rdata
    vecs[0]  = mk(1, 16'h0010, 0, 0, 16'h0000, 4'h0, 32'h0,        1, 0, 0, 4'h0, 4, 0, 0, 0, 32'h0);
    vecs[1]  = mk(0, 16'h0000, 0, 0, 16'h0000, 4'h0, 32'h0,        0, 0, 0, 4'h0, 0, 1, 0, 1, 32'h00500093);
    vecs[2]  = mk(0, 16'h0000, 1, 0, 16'h0020, 4'h0, 32'h0,        0, 1, 0, 4'h0, 8, 0, 0, 0, 32'h0);
    vecs[3]  = mk(1, 16'h0010, 1, 0, 16'h0020, 4'h0, 32'h0,        1, 0, 0, 4'h0, 4, 0, 1, 1, 32'h11111111);
    vecs[4]  = mk(1, 16'h0010, 1, 0, 16'h0020, 4'h0, 32'h0,        0, 1, 0, 4'h0, 8, 1, 0, 1, 32'h00500093);
    vecs[5]  = mk(1, 16'h0010, 1, 0, 16'h0020, 4'h0, 32'h0,        1, 0, 0, 4'h0, 4, 0, 1, 1, 32'h11111111);
    vecs[6]  = mk(1, 16'h0010, 1, 0, 16'h0020, 4'h0, 32'h0,        0, 1, 0, 4'h0, 8, 1, 0, 1, 32'h00500093);
    vecs[7]  = mk(0, 16'h0000, 0, 0, 16'h0000, 4'h0, 32'h0,        0, 0, 0, 4'h0, 0, 0, 1, 1, 32'h11111111);
    vecs[8]  = mk(0, 16'h0000, 1, 1, 16'h0008, 4'h3, 32'hAABBCCDD, 0, 1, 1, 4'h3, 2, 0, 0, 0, 32'h0);
    vecs[9]  = mk(1, 16'h0008, 0, 0, 16'h0000, 4'h0, 32'h0,        1, 0, 0, 4'h0, 2, 0, 0, 0, 32'h0);
    vecs[10] = mk(0, 16'h0000, 0, 0, 16'h0000, 4'h0, 32'h0,        0, 0, 0, 4'h0, 0, 1, 0, 1, 32'h0102CCDD);

    // Reset values (asynchronous, before any clock edge).
    idle_inputs();
    reset = 1;
    #2;
    chk("rst f_rvalid", 32'(f_rvalid), 32'd0);
    chk("rst d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst ld_ack", 32'(ld_ack), 32'd0);
    chk("rst ld_active", 32'(ld_active), 32'd0);
    chk("rst ld_count", 32'(ld_count), 32'd0);
    chk("rst m_we", 32'(m_we), 32'd0);
    chk("rst m_be", 32'(m_be), 32'd0);
    tick();
    tick();
    reset = 0;

    // Table-driven RUN-mode vectors.
    for (int i = 0; i < 11; i++) begin
      f_req = vecs[i].f_req; f_addr = vecs[i].f_addr;
      d_req = vecs[i].d_req; d_we = vecs[i].d_we; d_addr = vecs[i].d_addr;
      d_be = vecs[i].d_be; d_wdata = vecs[i].d_wdata;
      #4;
      chk($sformatf("row%0d f_gnt", i), 32'(f_gnt), 32'(vecs[i].e_fgnt));
      chk($sformatf("row%0d d_gnt", i), 32'(d_gnt), 32'(vecs[i].e_dgnt));
      chk($sformatf("row%0d m_we", i), 32'(m_we), 32'(vecs[i].e_we));
      chk($sformatf("row%0d m_be", i), 32'(m_be), 32'(vecs[i].e_be));
      chk($sformatf("row%0d m_addr", i), 32'(m_addr), 32'(vecs[i].e_addr));
      chk($sformatf("row%0d f_rvalid", i), 32'(f_rvalid), 32'(vecs[i].e_frv));
      chk($sformatf("row%0d d_rvalid", i), 32'(d_rvalid), 32'(vecs[i].e_drv));
      if (vecs[i].e_we)
        chk($sformatf("row%0d m_wdata", i), m_wdata, vecs[i].d_wdata);
      if (vecs[i].e_rdchk) begin
        if (vecs[i].e_frv) chk($sformatf("row%0d f_rdata", i), f_rdata, vecs[i].e_rdata);
        else               chk($sformatf("row%0d d_rdata", i), d_rdata, vecs[i].e_rdata);
      end
      tick();
    end
    idle_inputs();

    // Loader entry: fetch granted in N, ld_en in N+1.
    f_req = 1; f_addr = 16'h0010;
    #4;
    chk("ldN f_gnt", 32'(f_gnt), 32'd1);
    chk("ldN m_addr", 32'(m_addr), 32'd4);
    tick();
    f_addr = 16'h0020; ld_en = 1;
    #4;
    chk("ldN1 f_gnt", 32'(f_gnt), 32'd0);
    chk("ldN1 f_rvalid", 32'(f_rvalid), 32'd1);
    chk("ldN1 f_rdata", f_rdata, 32'h00500093);
    chk("ldN1 ld_active", 32'(ld_active), 32'd0);
    tick();
    #4;
    chk("drain f_gnt", 32'(f_gnt), 32'd0);
    chk("drain f_rvalid", 32'(f_rvalid), 32'd0);
    chk("drain ld_active", 32'(ld_active), 32'd0);
    tick();
    // LOAD: three back-to-back writes.
    ld_valid = 1; ld_we = 1; ld_addr = 14'd5; ld_wdata = 32'hA5A5A5A5;
    #4;
    chk("load ld_active", 32'(ld_active), 32'd1);
    chk("load f_gnt", 32'(f_gnt), 32'd0);
    chk("load ld_count", 32'(ld_count), 32'd0);
    chk("load m_we", 32'(m_we), 32'd1);
    chk("load m_be", 32'(m_be), 32'hF);
    chk("load m_addr", 32'(m_addr), 32'd5);
    tick();
    ld_addr = 14'd6; ld_wdata = 32'h5A5A5A5A;
    #4;
    chk("wr2 ld_ack", 32'(ld_ack), 32'd1);
    chk("wr2 m_addr", 32'(m_addr), 32'd6);
    tick();
    ld_addr = 14'd7; ld_wdata = 32'h12345678;
    #4;
    chk("wr3 ld_ack", 32'(ld_ack), 32'd1);
    chk("wr3 m_wdata", m_wdata, 32'h12345678);
    tick();
    // Readback of word 7 in the same cycle ld_en falls.
    ld_we = 0; ld_en = 0;
    #4;
    chk("rb m_we", 32'(m_we), 32'd0);
    chk("rb m_be", 32'(m_be), 32'd0);
    chk("rb m_addr", 32'(m_addr), 32'd7);
    chk("rb ld_ack", 32'(ld_ack), 32'd1);
    chk("rb ld_active", 32'(ld_active), 32'd1);
    chk("rb f_gnt", 32'(f_gnt), 32'd0);
    tick();
    ld_valid = 0;
    #4;
    chk("exit f_gnt", 32'(f_gnt), 32'd1);
    chk("exit m_addr", 32'(m_addr), 32'd8);
    chk("exit ld_ack", 32'(ld_ack), 32'd1);
    chk("exit ld_rdata", ld_rdata, 32'h12345678);
    chk("exit ld_active", 32'(ld_active), 32'd0);
    chk("exit ld_count", 32'(ld_count), 32'd3);
    tick();
    f_req = 0;
    #4;
    chk("held f_rvalid", 32'(f_rvalid), 32'd1);
    chk("held f_rdata", f_rdata, 32'h11111111);
    chk("held ld_ack", 32'(ld_ack), 32'd0);
    chk("held ld_count", 32'(ld_count), 32'd3);
    tick();

    // Re-enter LOAD, then async reset with a loader write in flight.
    ld_en = 1;
    tick();
    tick();
    ld_valid = 1; ld_we = 1; ld_addr = 14'd9; ld_wdata = 32'hDEADBEEF;
    #2;
    chk("reload ld_active", 32'(ld_active), 32'd1);
    chk("reload ld_count", 32'(ld_count), 32'd0);
    reset = 1;
    #1;
    chk("arst ld_active", 32'(ld_active), 32'd0);
    chk("arst ld_ack", 32'(ld_ack), 32'd0);
    chk("arst ld_count", 32'(ld_count), 32'd0);
    chk("arst m_we", 32'(m_we), 32'd0);
    idle_inputs();
    tick();
    chk("arst hold ld_ack", 32'(ld_ack), 32'd0);
    reset = 0;
    f_req = 1; f_addr = 16'h0010; d_req = 1; d_addr = 16'h0020;
    #4;
    chk("post f_gnt", 32'(f_gnt), 32'd1);
    chk("post d_gnt", 32'(d_gnt), 32'd0);
    chk("post ld_ack", 32'(ld_ack), 32'd0);
    chk("post ld_active", 32'(ld_active), 32'd0);
    tick();
    #4;
    chk("post2 d_gnt", 32'(d_gnt), 32'd1);
    chk("post2 f_rvalid", 32'(f_rvalid), 32'd1);
    chk("post2 ld_ack", 32'(ld_ack), 32'd0);
    tick();
    idle_inputs();
    #4;
    chk("post3 d_rvalid", 32'(d_rvalid), 32'd1);
    chk("post3 d_rdata", d_rdata, 32'h11111111);
    chk("post3 f_rvalid", 32'(f_rvalid), 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
